// File: rtl/riscv_lsu_pkg.sv
// riscv_lsu_pkg: shared funct3 codes, FSM states and access-size helper for the load/store unit
package riscv_lsu_pkg;
    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LD  = 3'b011;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] LWU = 3'b110;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;
    localparam logic [2:0] SD  = 3'b011;

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} lsu_state_t;

    function automatic logic [3:0] size_bytes(input logic [1:0] sz);
        return 4'd1 << sz;
    endfunction
endpackage

// File: rtl/lsu_align.sv
// lsu_align: extracts/extends load data and merges store data into the top bytes of a doubleword
module lsu_align (
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [63:0] dword,
    input  logic [63:0] wdata,
    output logic [63:0] load_val,
    output logic [63:0] store_dw
);
    logic s;
    // accessed bytes are always the top N bytes of the doubleword at the address
    always_comb begin
        s = ~uns & dword[63];
        load_val = size == 2'd0 ? {{56{s}}, dword[63:56]} :
                   size == 2'd1 ? {{48{s}}, dword[63:48]} :
                   size == 2'd2 ? {{32{s}}, dword[63:32]} : dword;
        store_dw = size == 2'd0 ? {wdata[7:0], dword[55:0]} :
                   size == 2'd1 ? {wdata[15:0], dword[47:0]} :
                   size == 2'd2 ? {wdata[31:0], dword[31:0]} : wdata;
    end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: multi-cycle load/store sequencer with read-modify-write for sub-doubleword stores
module load_store_unit
    import riscv_lsu_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int XLEN   = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              is_store,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [XLEN-1:0]   wdata,
    output logic              ready,
    output logic              done,
    output logic              err,
    output logic [XLEN-1:0]   rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic [XLEN-1:0]   mem_rdata
);
    localparam int AW1 = ADDR_W + 1;

    lsu_state_t        state, state_n;
    logic              is_store_q, err_q, req_err;
    logic [2:0]        f3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [XLEN-1:0]   wdata_q, load_val, store_dw;
    logic [ADDR_W:0]   last;

    assign last     = {1'b0, addr} + AW1'(size_bytes(funct3[1:0])) - AW1'(1);
    assign req_err  = last[ADDR_W] | (is_store ? funct3[2] : funct3 == 3'b111);
    assign mem_addr = addr_q;

    lsu_align u_align (
        .size     (f3_q[1:0]),
        .uns      (f3_q[2]),
        .dword    (mem_rdata),
        .wdata    (wdata_q),
        .load_val (load_val),
        .store_dw (store_dw)
    );

    // next state and state-decoded strobes so memory controls never glitch
    always_comb begin
        state_n   = state;
        ready     = state == IDLE;
        done      = state == RESP;
        err       = (state == RESP) & err_q;
        mem_read  = state == READ;
        mem_write = state == WRITE;
        case (state)
            IDLE:    if (req) state_n = req_err ? RESP : (is_store && funct3[1:0] == 2'b11) ? WRITE : READ;
            READ:    state_n = is_store_q ? WRITE : RESP;
            WRITE:   state_n = RESP;
            default: state_n = IDLE;
        endcase
    end

    // state, request latches, load result and write-back doubleword
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            is_store_q <= 1'b0;
            err_q      <= 1'b0;
            f3_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata      <= '0;
            mem_wdata  <= '0;
        end else begin
            state <= state_n;
            if (req && state == IDLE) begin
                is_store_q <= is_store;
                err_q      <= req_err;
                f3_q       <= funct3;
                addr_q     <= addr;
                wdata_q    <= wdata;
                mem_wdata  <= wdata;
            end
            if (state == READ && is_store_q) mem_wdata <= store_dw;
            if (state == READ && !is_store_q) rdata <= load_val;
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: scoreboard bench with a byte-array memory and an independent reference model
module tb_load_store_unit;
    typedef struct packed {
        logic        err;
        logic [63:0] rdata;
        logic [3:0]  lat;
        logic [3:0]  rd;
        logic [3:0]  wr;
    } resp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req = 1'b0;
    logic        is_store = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [7:0]  addr = '0;
    logic [63:0] wdata = '0;
    logic        ready, done, err, mem_read, mem_write;
    logic [63:0] rdata, mem_wdata, mem_rdata;
    logic [7:0]  mem_addr;

    logic [7:0]  mem [256];
    logic [7:0]  ref_mem [256];
    logic [63:0] last_rd;
    resp_t       sb [$];
    int          passed = 0;
    int          total = 0;

    load_store_unit #(.ADDR_W(8), .XLEN(64)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .is_store  (is_store),
        .funct3    (funct3),
        .addr      (addr),
        .wdata     (wdata),
        .ready     (ready),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    always_comb begin
        mem_rdata = '0;
        for (int i = 0; i < 8; i++)
            if (int'(mem_addr) + i < 256) mem_rdata[63-8*i -: 8] = mem[int'(mem_addr) + i];
    end

    always @(posedge clk)
        if (mem_write)
            for (int i = 0; i < 8; i++)
                if (int'(mem_addr) + i < 256) mem[int'(mem_addr) + i] <= mem_wdata[63-8*i -: 8];

    function automatic resp_t model(input logic st, input logic [2:0] f3, input logic [7:0] a, input logic [63:0] wd);
        resp_t r;
        int n;
        logic [63:0] v;
        n = 1 << f3[1:0];
        r.err = (int'(a) + n - 1 > 255) || (st ? f3[2] : f3 == 3'b111);
        r.lat = r.err ? 4'd1 : (st && n < 8) ? 4'd3 : 4'd2;
        r.rd = (!r.err && !(st && n == 8)) ? 4'd1 : 4'd0;
        r.wr = (!r.err && st) ? 4'd1 : 4'd0;
        if (!r.err && !st) begin
            v = '0;
            for (int i = 0; i < n; i++) v = (v << 8) | 64'(ref_mem[int'(a) + i]);
            if (!f3[2] && v[8*n-1]) v = v | ~((64'd1 << (8*n)) - 64'd1);
            if (n == 8) v = (v << 0);
            last_rd = v;
        end
        if (!r.err && st)
            for (int i = 0; i < n; i++) ref_mem[int'(a) + i] = wd[8*(n-1-i) +: 8];
        r.rdata = last_rd;
        return r;
    endfunction

    task automatic issue(input logic st, input logic [2:0] f3, input logic [7:0] a, input logic [63:0] wd, output int w);
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!ready && w < 8);
        sb.push_back(model(st, f3, a, wd));
        req = 1'b1;
        is_store = st;
        funct3 = f3;
        addr = a;
        wdata = wd;
        @(posedge clk);
        #1 req = 1'b0;
    endtask

    task automatic collect(output resp_t r);
        r = '0;
        do begin
            @(negedge clk);
            r.lat++;
            r.rd += 4'(mem_read);
            r.wr += 4'(mem_write);
        end while (!done && r.lat < 8);
        r.err = err;
        r.rdata = rdata;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        #12;
        total++; if (ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", ready); else passed++;
        total++; if (done !== 1'b0 || err !== 1'b0) $display("FAIL reset_done_err got=%b%b exp=00", done, err); else passed++;
        total++; if (rdata !== 64'd0) $display("FAIL reset_rdata got=%h exp=0", rdata); else passed++;
        total++; if (mem_read !== 1'b0 || mem_write !== 1'b0) $display("FAIL reset_strobes got=%b%b exp=00", mem_read, mem_write); else passed++;
        total++; if (mem_addr !== 8'd0 || mem_wdata !== 64'd0) $display("FAIL reset_mem_bus got=%h/%h exp=0/0", mem_addr, mem_wdata); else passed++;
        @(negedge clk);
        reset = 1'b0;
        last_rd = '0;
    endtask

    task automatic xact(input string name, input logic st, input logic [2:0] f3, input logic [7:0] a, input logic [63:0] wd);
        resp_t got, exp;
        int w;
        issue(st, f3, a, wd, w);
        collect(got);
        exp = sb.pop_front();
        total++;
        if (got !== exp)
            $display("FAIL %s got err=%b rdata=%h lat=%0d rd=%0d wr=%0d exp err=%b rdata=%h lat=%0d rd=%0d wr=%0d",
                     name, got.err, got.rdata, got.lat, got.rd, got.wr, exp.err, exp.rdata, exp.lat, exp.rd, exp.wr);
        else passed++;
    endtask

    task automatic test_load;
        xact("ld_0", 1'b0, 3'b011, 8'd0, '0);
        xact("lb_7", 1'b0, 3'b000, 8'd7, '0);
        xact("lwu_3", 1'b0, 3'b110, 8'd3, '0);
    endtask

    task automatic test_store_byte;
        xact("sb_8", 1'b1, 3'b000, 8'd8, 64'h00000000000000FF);
        xact("ld_8", 1'b0, 3'b011, 8'd8, '0);
        xact("lb_8", 1'b0, 3'b000, 8'd8, '0);
        xact("lbu_8", 1'b0, 3'b100, 8'd8, '0);
    endtask

    task automatic test_store_half;
        xact("sh_16", 1'b1, 3'b001, 8'd16, 64'h000000000000ABCD);
        xact("ld_16", 1'b0, 3'b011, 8'd16, '0);
        xact("lh_16", 1'b0, 3'b001, 8'd16, '0);
        xact("sw_37", 1'b1, 3'b010, 8'd37, 64'h00000000DEADBEEF);
        xact("ld_36", 1'b0, 3'b011, 8'd36, '0);
    endtask

    task automatic test_store_dword;
        xact("sd_248", 1'b1, 3'b011, 8'd248, 64'h0123456789ABCDEF);
        xact("ld_248", 1'b0, 3'b011, 8'd248, '0);
        xact("sd_249", 1'b1, 3'b011, 8'd249, 64'h1111111111111111);
        xact("lb_255", 1'b0, 3'b000, 8'd255, '0);
        xact("lh_255", 1'b0, 3'b001, 8'd255, '0);
        xact("ld_248_again", 1'b0, 3'b011, 8'd248, '0);
    endtask

    task automatic test_illegal;
        xact("load_f3_7", 1'b0, 3'b111, 8'd40, '0);
        xact("store_f3_4", 1'b1, 3'b100, 8'd40, 64'hFFFFFFFFFFFFFFFF);
        xact("ld_40", 1'b0, 3'b011, 8'd40, '0);
    endtask

    task automatic test_back_to_back;
        resp_t got, exp;
        int w;
        xact("b2b_first", 1'b0, 3'b010, 8'd100, '0);
        issue(1'b0, 3'b101, 8'd102, '0, w);
        total++; if (w !== 1) $display("FAIL b2b_accept_gap got=%0d exp=1", w); else passed++;
        collect(got);
        exp = sb.pop_front();
        total++; if (got !== exp) $display("FAIL b2b_second got=%h/%0d exp=%h/%0d", got.rdata, got.lat, exp.rdata, exp.lat); else passed++;
    endtask

    task automatic test_abort;
        int seen = 0;
        @(negedge clk);
        req = 1'b1; is_store = 1'b1; funct3 = 3'b001; addr = 8'd16; wdata = 64'h5555;
        @(posedge clk);
        #1 req = 1'b0;
        #1 reset = 1'b1;
        #1;
        total++; if (mem_read !== 1'b0 || ready !== 1'b1) $display("FAIL abort_read got rd=%b ready=%b exp rd=0 ready=1", mem_read, ready); else passed++;
        @(negedge clk);
        reset = 1'b0;
        last_rd = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            seen += int'(done);
        end
        total++; if (seen !== 0) $display("FAIL abort_no_done got=%0d exp=0", seen); else passed++;
        xact("ld_16_after_abort", 1'b0, 3'b011, 8'd16, '0);
        @(negedge clk);
        req = 1'b1; is_store = 1'b1; funct3 = 3'b000; addr = 8'd8; wdata = 64'h11;
        @(posedge clk);
        #1 req = 1'b0;
        @(posedge clk);
        #2;
        total++; if (mem_write !== 1'b1) $display("FAIL abort_in_write_state got=%b exp=1", mem_write); else passed++;
        reset = 1'b1;
        #1;
        total++; if (mem_write !== 1'b0 || done !== 1'b0) $display("FAIL abort_write got wr=%b done=%b exp 0 0", mem_write, done); else passed++;
        @(negedge clk);
        reset = 1'b0;
        last_rd = '0;
        xact("ld_8_after_abort", 1'b0, 3'b011, 8'd8, '0);
    endtask

    task automatic test_random;
        for (int k = 0; k < 24; k++)
            xact("random", 1'($urandom), 3'($urandom), 8'($urandom), {$urandom, $urandom});
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'(i + 1);
            ref_mem[i] = 8'(i + 1);
        end
        last_rd = '0;
        test_reset;
        test_load;
        test_store_byte;
        test_store_half;
        test_store_dword;
        test_illegal;
        test_back_to_back;
        test_abort;
        test_random;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
